// File: rtl/rv32i_defs.sv
// Shared encodings for the multi-cycle rv32i control path: states, opcodes,
// ALU/mux select codes and the bundled control-output record.
package rv32i_defs;

   typedef enum logic [3:0] {
      ST_BOOT   = 4'd0,
      ST_FETCH  = 4'd1,
      ST_DECODE = 4'd2,
      ST_EXEC   = 4'd3,
      ST_MEM    = 4'd4,
      ST_WB     = 4'd5,
      ST_HALT   = 4'd6
   } state_e;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [1:0] ALU_ADD    = 2'b00;
   localparam logic [1:0] ALU_BRANCH = 2'b01;
   localparam logic [1:0] ALU_ITYPE  = 2'b10;
   localparam logic [1:0] ALU_RTYPE  = 2'b11;

   localparam logic [1:0] PC_PLUS4 = 2'b00;
   localparam logic [1:0] PC_ALU   = 2'b01;
   localparam logic [1:0] PC_RESET = 2'b11;

   localparam logic [1:0] SRC_A_RS1  = 2'b00;
   localparam logic [1:0] SRC_A_PC   = 2'b01;
   localparam logic [1:0] SRC_A_ZERO = 2'b10;

   localparam logic [1:0] SRC_B_RS2  = 2'b00;
   localparam logic [1:0] SRC_B_IMM  = 2'b01;
   localparam logic [1:0] SRC_B_FOUR = 2'b10;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       ir_write;
      logic       pc_write;
      logic [1:0] pc_src;
      logic [1:0] alu_op;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic       reg_write;
      logic [1:0] wb_sel;
      logic       halted;
   } ctrl_t;

   function automatic logic is_legal_op(input logic [6:0] op);
      case (op)
         OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
         OP_LUI, OP_AUIPC, OP_SYSTEM: return 1'b1;
         default:                     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/control_out_decode.sv
// Combinational map from controller state and latched opcode to the datapath
// control vector; everything is forced inactive while the core is in reset.
module control_out_decode
   import rv32i_defs::*;
#(
   parameter logic [1:0] RESET_PC_SEL = PC_RESET
) (
   input  logic       active,
   input  state_e     state,
   input  logic [6:0] opcode,
   input  logic       branch_taken,
   input  logic       mem_ready,
   input  logic       boot_last,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl = '0;
      if (active) begin
         case (state)
            ST_BOOT: begin
               ctrl.pc_src   = RESET_PC_SEL;
               ctrl.pc_write = boot_last;
            end
            ST_FETCH: begin
               ctrl.mem_req = 1'b1;
               if (mem_ready) begin
                  ctrl.ir_write  = 1'b1;
                  ctrl.pc_write  = 1'b1;
                  ctrl.pc_src    = PC_PLUS4;
                  ctrl.alu_src_a = SRC_A_PC;
                  ctrl.alu_src_b = SRC_B_FOUR;
                  ctrl.alu_op    = ALU_ADD;
               end
            end
            ST_EXEC: begin
               case (opcode)
                  OP_R: ctrl.alu_op = ALU_RTYPE;
                  OP_I: begin
                     ctrl.alu_op    = ALU_ITYPE;
                     ctrl.alu_src_b = SRC_B_IMM;
                  end
                  OP_LOAD, OP_STORE: ctrl.alu_src_b = SRC_B_IMM;
                  OP_BRANCH: begin
                     // Target comes from the dedicated imm adder, so the ALU stays on compare.
                     ctrl.alu_op = ALU_BRANCH;
                     if (branch_taken) begin
                        ctrl.pc_write = 1'b1;
                        ctrl.pc_src   = PC_ALU;
                     end
                  end
                  OP_JAL, OP_JALR: begin
                     ctrl.alu_src_a = (opcode == OP_JAL) ? SRC_A_PC : SRC_A_RS1;
                     ctrl.alu_src_b = SRC_B_IMM;
                     ctrl.pc_write  = 1'b1;
                     ctrl.pc_src    = PC_ALU;
                     ctrl.reg_write = 1'b1;
                     ctrl.wb_sel    = WB_PC4;
                  end
                  OP_LUI: begin
                     ctrl.alu_src_a = SRC_A_ZERO;
                     ctrl.alu_src_b = SRC_B_IMM;
                  end
                  OP_AUIPC: begin
                     ctrl.alu_src_a = SRC_A_PC;
                     ctrl.alu_src_b = SRC_B_IMM;
                  end
                  default: ;
               endcase
            end
            ST_MEM: begin
               ctrl.mem_req = 1'b1;
               ctrl.mem_we  = (opcode == OP_STORE);
            end
            ST_WB: begin
               ctrl.reg_write = 1'b1;
               ctrl.wb_sel    = (opcode == OP_LOAD) ? WB_MEM : WB_ALU;
            end
            ST_HALT: ctrl.halted = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/multicycle_control.sv
// Main sequencing FSM of the multi-cycle rv32i core: boot, fetch, decode,
// execute, memory and writeback, with a sticky halt on illegal/system opcodes.
module multicycle_control
   import rv32i_defs::*;
#(
   parameter int         BOOT_CYCLES  = 2,
   parameter logic [1:0] RESET_PC_SEL = 2'b11
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] fun3,
   input  logic       imm_zero_ebreak,
   input  logic       branch_taken,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic [1:0] alu_op,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic       reg_write,
   output logic [1:0] wb_sel,
   output logic       halted,
   output logic [3:0] state_dbg
);

   state_e     state;
   logic [3:0] boot_cnt;
   logic [6:0] op_q;
   logic [2:0] fun3_q;
   logic       boot_last;
   logic       sys_ebreak;
   logic       sys_other;
   logic       halt_dec;
   logic       unused_fun3;
   ctrl_t      ctrl;

   assign boot_last  = (boot_cnt == 4'(BOOT_CYCLES - 1));
   // Both SYSTEM flavours stop the core: EBREAK on purpose, anything else as unsupported.
   assign sys_ebreak = (opcode == OP_SYSTEM) &  imm_zero_ebreak;
   assign sys_other  = (opcode == OP_SYSTEM) & ~imm_zero_ebreak;
   assign halt_dec   = !is_legal_op(opcode) | sys_ebreak | sys_other;
   // fun3 is held alongside the opcode for fun3-qualified decode; nothing consumes it yet.
   assign unused_fun3 = ^fun3_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_BOOT;
         boot_cnt <= '0;
         op_q     <= '0;
         fun3_q   <= '0;
      end else begin
         case (state)
            ST_BOOT: begin
               if (boot_last) state <= ST_FETCH;
               else           boot_cnt <= boot_cnt + 4'd1;
            end
            ST_FETCH: if (mem_ready) state <= ST_DECODE;
            ST_DECODE: begin
               op_q   <= opcode;
               fun3_q <= fun3;
               state  <= halt_dec ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
               case (op_q)
                  OP_R, OP_I, OP_LUI, OP_AUIPC:  state <= ST_WB;
                  OP_LOAD, OP_STORE:             state <= ST_MEM;
                  OP_BRANCH, OP_JAL, OP_JALR:    state <= ST_FETCH;
                  default:                       state <= ST_HALT;
               endcase
            end
            ST_MEM: if (mem_ready) state <= (op_q == OP_LOAD) ? ST_WB : ST_FETCH;
            ST_WB:   state <= ST_FETCH;
            ST_HALT: state <= ST_HALT;
            default: state <= ST_HALT;
         endcase
      end
   end

   control_out_decode #(
      .RESET_PC_SEL(RESET_PC_SEL)
   ) u_decode (
      .active       (!rst),
      .state        (state),
      .opcode       (op_q),
      .branch_taken (branch_taken),
      .mem_ready    (mem_ready),
      .boot_last    (boot_last),
      .ctrl         (ctrl)
   );

   assign mem_req   = ctrl.mem_req;
   assign mem_we    = ctrl.mem_we;
   assign ir_write  = ctrl.ir_write;
   assign pc_write  = ctrl.pc_write;
   assign pc_src    = ctrl.pc_src;
   assign alu_op    = ctrl.alu_op;
   assign alu_src_a = ctrl.alu_src_a;
   assign alu_src_b = ctrl.alu_src_b;
   assign reg_write = ctrl.reg_write;
   assign wb_sel    = ctrl.wb_sel;
   assign halted    = ctrl.halted;
   assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a per-cycle vector table for the
// instruction classes, then hand-written reset/halt sequences.
module tb_multicycle_control;

   localparam logic [6:0] R_OP   = 7'b0110011;
   localparam logic [6:0] I_OP   = 7'b0010011;
   localparam logic [6:0] LD_OP  = 7'b0000011;
   localparam logic [6:0] ST_OP  = 7'b0100011;
   localparam logic [6:0] BR_OP  = 7'b1100011;
   localparam logic [6:0] JAL_OP = 7'b1101111;
   localparam logic [6:0] JR_OP  = 7'b1100111;
   localparam logic [6:0] LUI_OP = 7'b0110111;
   localparam logic [6:0] AUI_OP = 7'b0010111;
   localparam logic [6:0] SYS_OP = 7'b1110011;

   // Field order: req we irw pcw pc_src alu_op src_a src_b rw wb_sel halted
   localparam logic [15:0] IDLE      = 16'b0_0_0_0_00_00_00_00_0_00_0;
   localparam logic [15:0] BOOT_WAIT = 16'b0_0_0_0_11_00_00_00_0_00_0;
   localparam logic [15:0] BOOT_PCW  = 16'b0_0_0_1_11_00_00_00_0_00_0;
   localparam logic [15:0] FETCH_OK  = 16'b1_0_1_1_00_00_01_10_0_00_0;
   localparam logic [15:0] REQ_RD    = 16'b1_0_0_0_00_00_00_00_0_00_0;
   localparam logic [15:0] REQ_WR    = 16'b1_1_0_0_00_00_00_00_0_00_0;
   localparam logic [15:0] EX_R      = 16'b0_0_0_0_00_11_00_00_0_00_0;
   localparam logic [15:0] EX_I      = 16'b0_0_0_0_00_10_00_01_0_00_0;
   localparam logic [15:0] EX_LS     = 16'b0_0_0_0_00_00_00_01_0_00_0;
   localparam logic [15:0] EX_BR_T   = 16'b0_0_0_1_01_01_00_00_0_00_0;
   localparam logic [15:0] EX_BR_N   = 16'b0_0_0_0_00_01_00_00_0_00_0;
   localparam logic [15:0] EX_JAL    = 16'b0_0_0_1_01_00_01_01_1_10_0;
   localparam logic [15:0] EX_JALR   = 16'b0_0_0_1_01_00_00_01_1_10_0;
   localparam logic [15:0] EX_LUI    = 16'b0_0_0_0_00_00_10_01_0_00_0;
   localparam logic [15:0] EX_AUI    = 16'b0_0_0_0_00_00_01_01_0_00_0;
   localparam logic [15:0] WB_ALU    = 16'b0_0_0_0_00_00_00_00_1_00_0;
   localparam logic [15:0] WB_MEM    = 16'b0_0_0_0_00_00_00_00_1_01_0;
   localparam logic [15:0] HALTED    = 16'b0_0_0_0_00_00_00_00_0_00_1;

   typedef struct {
      string       nm;
      logic [6:0]  op;
      logic        br;
      logic        rdy;
      logic [3:0]  st;
      logic [15:0] exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] opcode;
   logic [2:0] fun3;
   logic       imm_zero_ebreak;
   logic       branch_taken;
   logic       mem_ready;
   logic       mem_req, mem_we, ir_write, pc_write, reg_write, halted;
   logic [1:0] pc_src, alu_op, alu_src_a, alu_src_b, wb_sel;
   logic [3:0] state_dbg;

   int   errors = 0;
   int   checks = 0;
   vec_t tv[$];

   always #5 clk = ~clk;

   multicycle_control #(
      .BOOT_CYCLES  (2),
      .RESET_PC_SEL (2'b11)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .opcode          (opcode),
      .fun3            (fun3),
      .imm_zero_ebreak (imm_zero_ebreak),
      .branch_taken    (branch_taken),
      .mem_ready       (mem_ready),
      .mem_req         (mem_req),
      .mem_we          (mem_we),
      .ir_write        (ir_write),
      .pc_write        (pc_write),
      .pc_src          (pc_src),
      .alu_op          (alu_op),
      .alu_src_a       (alu_src_a),
      .alu_src_b       (alu_src_b),
      .reg_write       (reg_write),
      .wb_sel          (wb_sel),
      .halted          (halted),
      .state_dbg       (state_dbg)
   );

   function automatic logic [15:0] outs();
      return {mem_req, mem_we, ir_write, pc_write, pc_src, alu_op,
              alu_src_a, alu_src_b, reg_write, wb_sel, halted};
   endfunction

   task automatic chk(input string nm, input logic [3:0] st, input logic [15:0] exp);
      checks++;
      if (state_dbg !== st || outs() !== exp) begin
         errors++;
         $display("FAIL %s: got state=%0d outs=%b, required state=%0d outs=%b",
                  nm, state_dbg, outs(), st, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      opcode = '0;
      fun3 = 3'b000;
      imm_zero_ebreak = 1'b0;
      branch_taken = 1'b0;
      mem_ready = 1'b1;

      tv.push_back('{"boot0",      R_OP,   1'b0, 1'b1, 4'd0, BOOT_WAIT});
      tv.push_back('{"boot1",      R_OP,   1'b0, 1'b1, 4'd0, BOOT_PCW});
      tv.push_back('{"add fetch",  R_OP,   1'b0, 1'b1, 4'd1, FETCH_OK});
      tv.push_back('{"add dec",    R_OP,   1'b0, 1'b1, 4'd2, IDLE});
      tv.push_back('{"add exec",   R_OP,   1'b0, 1'b1, 4'd3, EX_R});
      tv.push_back('{"add wb",     R_OP,   1'b0, 1'b1, 4'd5, WB_ALU});
      tv.push_back('{"addi wait",  I_OP,   1'b0, 1'b0, 4'd1, REQ_RD});
      tv.push_back('{"addi fetch", I_OP,   1'b0, 1'b1, 4'd1, FETCH_OK});
      tv.push_back('{"addi dec",   I_OP,   1'b0, 1'b1, 4'd2, IDLE});
      tv.push_back('{"addi exec",  I_OP,   1'b0, 1'b1, 4'd3, EX_I});
      tv.push_back('{"addi wb",    I_OP,   1'b0, 1'b1, 4'd5, WB_ALU});
      tv.push_back('{"beq fetch",  BR_OP,  1'b1, 1'b1, 4'd1, FETCH_OK});
      tv.push_back('{"beq dec",    BR_OP,  1'b1, 1'b1, 4'd2, IDLE});
      tv.push_back('{"beq taken",  BR_OP,  1'b1, 1'b1, 4'd3, EX_BR_T});
      tv.push_back('{"beq2 fetch", BR_OP,  1'b0, 1'b1, 4'd1, FETCH_OK});
      tv.push_back('{"beq2 dec",   BR_OP,  1'b0, 1'b1, 4'd2, IDLE});
      tv.push_back('{"beq ntaken", BR_OP,  1'b0, 1'b1, 4'd3, EX_BR_N});
      tv.push_back('{"jal fetch",  JAL_OP, 1'b0, 1'b1, 4'd1, FETCH_OK});
      tv.push_back('{"jal dec",    JAL_OP, 1'b0, 1'b1, 4'd2, IDLE});
      tv.push_back('{"jal exec",   JAL_OP, 1'b0, 1'b1, 4'd3, EX_JAL});
      tv.push_back('{"jalr fetch", JR_OP,  1'b0, 1'b1, 4'd1, FETCH_OK});
      tv.push_back('{"jalr dec",   JR_OP,  1'b0, 1'b1, 4'd2, IDLE});
      tv.push_back('{"jalr exec",  JR_OP,  1'b0, 1'b1, 4'd3, EX_JALR});
      tv.push_back('{"lui fetch",  LUI_OP, 1'b0, 1'b1, 4'd1, FETCH_OK});
      tv.push_back('{"lui dec",    LUI_OP, 1'b0, 1'b1, 4'd2, IDLE});
      tv.push_back('{"lui exec",   LUI_OP, 1'b0, 1'b1, 4'd3, EX_LUI});
      tv.push_back('{"lui wb",     LUI_OP, 1'b0, 1'b1, 4'd5, WB_ALU});
      tv.push_back('{"aui fetch",  AUI_OP, 1'b0, 1'b1, 4'd1, FETCH_OK});
      tv.push_back('{"aui dec",    AUI_OP, 1'b0, 1'b1, 4'd2, IDLE});
      tv.push_back('{"aui exec",   AUI_OP, 1'b0, 1'b1, 4'd3, EX_AUI});
      tv.push_back('{"aui wb",     AUI_OP, 1'b0, 1'b1, 4'd5, WB_ALU});
      tv.push_back('{"sw fetch",   ST_OP,  1'b0, 1'b1, 4'd1, FETCH_OK});
      tv.push_back('{"sw dec",     ST_OP,  1'b0, 1'b1, 4'd2, IDLE});
      tv.push_back('{"sw exec",    ST_OP,  1'b0, 1'b1, 4'd3, EX_LS});
      tv.push_back('{"sw mem w",   ST_OP,  1'b0, 1'b0, 4'd4, REQ_WR});
      tv.push_back('{"sw mem",     ST_OP,  1'b0, 1'b1, 4'd4, REQ_WR});
      tv.push_back('{"lw fetch",   LD_OP,  1'b0, 1'b1, 4'd1, FETCH_OK});
      tv.push_back('{"lw dec",     LD_OP,  1'b0, 1'b1, 4'd2, IDLE});
      tv.push_back('{"lw exec",    LD_OP,  1'b0, 1'b1, 4'd3, EX_LS});
      tv.push_back('{"lw mem w1",  LD_OP,  1'b0, 1'b0, 4'd4, REQ_RD});
      tv.push_back('{"lw mem w2",  LD_OP,  1'b0, 1'b0, 4'd4, REQ_RD});
      tv.push_back('{"lw mem w3",  LD_OP,  1'b0, 1'b0, 4'd4, REQ_RD});
      tv.push_back('{"lw mem",     LD_OP,  1'b0, 1'b1, 4'd4, REQ_RD});
      tv.push_back('{"lw wb",      LD_OP,  1'b0, 1'b1, 4'd5, WB_MEM});
      tv.push_back('{"lw2 fetch",  LD_OP,  1'b0, 1'b1, 4'd1, FETCH_OK});
      tv.push_back('{"lw2 dec",    LD_OP,  1'b0, 1'b1, 4'd2, IDLE});
      tv.push_back('{"lw2 exec",   LD_OP,  1'b0, 1'b1, 4'd3, EX_LS});
      tv.push_back('{"lw2 mem w",  LD_OP,  1'b0, 1'b0, 4'd4, REQ_RD});

      cyc();
      cyc();
      #1 chk("in reset", 4'd0, IDLE);
      rst = 1'b0;

      for (int i = 0; i < tv.size(); i++) begin
         opcode       = tv[i].op;
         branch_taken = tv[i].br;
         mem_ready    = tv[i].rdy;
         #1 chk(tv[i].nm, tv[i].st, tv[i].exp);
         cyc();
      end

      // Abandon an outstanding load: request must drop with the reset itself.
      mem_ready = 1'b0;
      #1 chk("mem held", 4'd4, REQ_RD);
      rst = 1'b1;
      #1 chk("rst mid mem", 4'd0, IDLE);
      cyc();
      rst = 1'b0;
      mem_ready = 1'b1;
      opcode = 7'b0000000;
      #1 chk("reboot0", 4'd0, BOOT_WAIT);
      cyc();
      #1 chk("reboot1", 4'd0, BOOT_PCW);
      cyc();
      #1 chk("illegal fetch", 4'd1, FETCH_OK);
      cyc();
      #1 chk("illegal dec", 4'd2, IDLE);
      cyc();
      for (int i = 0; i < 20; i++) begin
         #1 chk("halt hold", 4'd6, HALTED);
         cyc();
      end

      rst = 1'b1;
      #1 chk("rst from halt", 4'd0, IDLE);
      cyc();
      rst = 1'b0;
      cyc();
      opcode = SYS_OP;
      imm_zero_ebreak = 1'b1;
      cyc();
      #1 chk("ebreak fetch", 4'd1, FETCH_OK);
      cyc();
      #1 chk("ebreak dec", 4'd2, IDLE);
      cyc();
      #1 chk("ebreak halt", 4'd6, HALTED);
      cyc();
      #1 chk("ebreak sticky", 4'd6, HALTED);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main sequencing FSM for the multi-cycle rv32i core. It steps each instruction through fetch, decode, execute, memory and writeback. It drives the 2-bit alu_op that the ALU control decoder turns into an ALU operation, and it drives the datapath muxes and enables. It also handshakes with a single shared instruction/data memory port and halts on illegal opcodes or EBREAK.

Parameters:
BOOT_CYCLES, 2, cycles spent in BOOT after reset deassertion before the first fetch (range 1..15).
RESET_PC_SEL, 2'b11, pc_src value driven during BOOT so the PC loads the reset vector.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
opcode  in  7  instr[6:0] from the instruction register (valid from DECODE onward)
fun3  in  3  instr[14:12]
imm_zero_ebreak  in  1  high when instr[31:7]==0x00100 >> 7-aligned EBREAK pattern, decoded in the datapath
branch_taken  in  1  branch comparison result from the ALU/comparator, valid in EXEC
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
mem_we  out  1  write enable, qualified by mem_req
ir_write  out  1  load the instruction register
pc_write  out  1  load the PC
pc_src  out  2  00 pc+4, 01 alu result (branch/jal/jalr), 11 reset vector
alu_op  out  2  00 add, 01 branch compare, 10 I-type, 11 R-type
alu_src_a  out  2  00 rs1, 01 pc, 10 zero
alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4
reg_write  out  1  register-file write enable
wb_sel  out  2  00 alu, 01 mem data, 10 pc+4
halted  out  1  sticky; the core has stopped
state_dbg  out  4  current state encoding

Behaviour:
- States and encodings: BOOT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Encodings 7..15 are illegal and go to HALT.
- On rst: state=BOOT, boot counter=0, latched opcode=0, halted=0. All enables are 0, alu_op=00, all selects=00.
- BOOT: pc_src=11. When counter reaches BOOT_CYCLES-1, pulse pc_write and go to FETCH.
- FETCH: mem_req=1, mem_we=0. Hold FETCH while mem_ready=0.
  - When mem_ready=1, assert ir_write=1 and pc_write=1 that cycle with pc_src=00, alu_src_a=01, alu_src_b=10, alu_op=00. Then go to DECODE.
  - Minimum fetch latency is 1 cycle.
- DECODE: latch opcode and fun3 into internal registers. No enables.
  - Legal opcodes: 0110011 R, 0010011 I, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 1101111 JAL, 1100111 JALR, 0110111 LUI, 0010111 AUIPC, 1110011 SYSTEM (EBREAK only).
  - Illegal opcode, SYSTEM with imm_zero_ebreak=0, or SYSTEM EBREAK: go to HALT. Otherwise go to EXEC.
- EXEC, all outputs decoded from the latched opcode:
  - R: alu_op=11, src_a=00, src_b=00, then WB.
  - I: alu_op=10, src_a=00, src_b=01, then WB.
  - LOAD/STORE: alu_op=00, src_a=00, src_b=01, then MEM.
  - BRANCH: alu_op=01, src_a=00, src_b=00. If branch_taken, pc_write=1 and pc_src=01 (target from the adjacent imm adder). Then FETCH.
  - JAL: alu_op=00, src_a=01, src_b=01. JALR: alu_op=00, src_a=00, src_b=01. For both, pc_write=1, pc_src=01, reg_write=1, wb_sel=10, then FETCH. The writeback uses the pc+4 held in the datapath.
  - LUI: alu_op=00, src_a=10, src_b=01, then WB. AUIPC: alu_op=00, src_a=01, src_b=01, then WB.
- MEM: mem_req=1 and mem_we=(opcode==STORE). Address and write data stay stable while waiting.
  - Hold MEM while mem_ready=0.
  - On mem_ready: a LOAD goes to WB; a STORE goes to FETCH.
- WB: reg_write=1, one cycle. wb_sel=01 for LOAD, 00 otherwise. Then FETCH.
- HALT: all enables are 0 and halted=1. Only rst leaves HALT.
- mem_req stays 1 from FETCH/MEM entry until mem_ready. The controller never drops a request early.
- CPI: R/I/LUI/AUIPC = 4 + fetch wait. Branch/JAL/JALR = 3 + fetch wait. Store = 4 + waits. Load = 5 + waits.
- Reset mid-access: the state returns to BOOT immediately and mem_req drops asynchronously. The memory must tolerate an abandoned request.
- mem_ready outside FETCH/MEM is ignored.

Decomposition:
- Shared package/header `rv32i_defs`: opcode constants, the alu_op codes (00/01/10/11), pc_src/wb_sel/alu_src encodings, and the state encodings.
- Sub-module `control_out_decode`: a purely combinational map from {state, latched opcode, branch_taken, mem_ready} to the output vector. The FSM module keeps the state register, the boot counter and the opcode latch.

Test Plan:
- Reset, BOOT_CYCLES=2, mem_ready tied 1 -> first pc_write (pc_src=11) at cycle 2 after rst falls, mem_req rises cycle 3.
- ADD (opcode 0110011), mem_ready=1 -> state sequence FETCH, DECODE, EXEC (alu_op=11), WB (reg_write=1, wb_sel=00); next FETCH 4 cycles after the first.
- LW with mem_ready low 3 cycles in MEM -> mem_req held 4 cycles with mem_we=0, then WB with wb_sel=01. SW -> mem_we=1 and no reg_write.
- BEQ with branch_taken=1, then again with 0 -> pc_write/pc_src=01 pulse in EXEC only when taken; alu_op=01 both times.
- Opcode 0000000 -> HALT after DECODE, halted=1, no further mem_req for 20 cycles. Asserting rst then returns to BOOT.
- Assert rst while in MEM with mem_req=1 -> mem_req=0 in the same cycle, state_dbg=0.
